config_regfile: RTL
===================

Name: config_regfile

Overview:
- Downstream consumer of the frame-splitting config stage.
- Accepts address/data write requests over a valid/ack handshake and stores them in a 16-entry x 4-bit configuration register bank.
- Issues a one-cycle ack after a programmable delay, enforces a write lock, and exposes the register contents on a flat bus and a registered read port.
- Rejected writes are never acked, so the upstream stage times out and raises its fault.

Parameters:
ACK_DELAY, 2, cycles spent in DELAY before ack; legal range 0..5 (keeps ack inside the upstream 8-cycle timeout)
LOCK_KEY, 4'hA, data value written to address 15 that sets the lock
UNLOCK_KEY, 4'h5, data value written to address 15 that clears the lock

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous, active-high
valid  input  1  write request from the upstream config stage; held high until after ack
address  input  4  register index of the request
data  input  4  write data of the request
ack  output  1  registered; high for exactly one cycle per accepted write
rd_addr  input  4  read port index
rd_data  output  4  registered read data, 1-cycle latency
cfg_bus  output  60  registers 14..0 concatenated, reg n at bits [4n+3:4n]
locked  output  1  current lock state
reject_cnt  output  8  count of rejected writes, saturating at 255

Behaviour:
- Reset (synchronous, active-high, sampled on the clk rising edge): state = IDLE; all 15 data registers = 0; locked = 0; ack = 0; rd_data = 0; reject_cnt = 0; delay counter = 0. Reset mid-transaction aborts it with no ack and no write.
- Address 15 is the lock register, not storage:
  - data == LOCK_KEY sets locked.
  - data == UNLOCK_KEY clears locked.
  - Any other data leaves locked unchanged but is still acked.
  - A read of address 15 returns {3'b000, locked}.
- FSM states: IDLE, DELAY, ACK, HOLD, REJECT.
- IDLE:
  - On valid = 1, latch address and data.
  - If locked = 1 and address != 15, go to REJECT.
  - Else if ACK_DELAY == 0, go to ACK.
  - Else go to DELAY with counter cleared.
- DELAY: increment the counter each cycle; when counter == ACK_DELAY-1, go to ACK.
- Write commit: the write (or lock update) happens on the clock edge that enters ACK, using the latched address/data. Input changes after the IDLE capture are ignored.
- ACK: ack = 1 for exactly this one cycle, then always go to HOLD.
- HOLD:
  - Wait for valid = 0, then go to IDLE.
  - This prevents a second write from the one cycle in which upstream still holds valid after sampling ack.
- REJECT:
  - reject_cnt increments once on entry, saturating at 255; no write and no ack.
  - Stay until valid = 0, then go to IDLE.
- Latency: if valid is first sampled high at edge k, ack is high during cycle k+1+ACK_DELAY.
- Read port:
  - rd_data <= reg[rd_addr] on every edge.
  - A read and a commit to the same address on the same edge return the old value.
- cfg_bus and locked are direct register outputs, updated on the commit edge.
- valid rising while in DELAY/ACK/HOLD/REJECT is not a new request; only IDLE accepts requests.

Test Plan:
- Reset, then write addr 3 data 9 (ACK_DELAY=2), valid held until 1 cycle after ack -> ack high exactly in cycle k+3; cfg_bus[15:12] = 9; exactly one ack pulse; read rd_addr=3 returns 9 one cycle later.
- Write addr 15 data 4'hA, then addr 7 data 4 -> locked = 1 after the first ack; no ack for the second write; reg 7 unchanged; reject_cnt = 1; valid dropped by upstream after timeout returns the FSM to IDLE.
- While locked, write addr 15 data 4'h5, then addr 7 data 4 -> both acked; locked = 0; cfg_bus[31:28] = 4.
- Back-to-back writes to addr 0 (data 1, then 2), valid low for 1 cycle between them -> two acks; final reg 0 = 2; no extra write from the overlapping valid cycle.
- Assert rst while in DELAY -> no ack; no register change; state IDLE; all outputs 0 on the next cycle.
- 256 rejected writes while locked -> reject_cnt saturates at 255. With ACK_DELAY=0, an accepted write acks in cycle k+1.

Source files
------------

// File: rtl/config_regfile.sv
// Configuration register bank written over a valid/ack handshake, with a key-based
// write lock at address 15, a flat configuration bus and a registered read port.
module config_regfile #(
    parameter int         ACK_DELAY  = 2,
    parameter logic [3:0] LOCK_KEY   = 4'hA,
    parameter logic [3:0] UNLOCK_KEY = 4'h5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [3:0]  address,
    input  logic [3:0]  data,
    output logic        ack,
    input  logic [3:0]  rd_addr,
    output logic [3:0]  rd_data,
    output logic [59:0] cfg_bus,
    output logic        locked,
    output logic [7:0]  reject_cnt
);

    typedef enum logic [2:0] {IDLE, DELAY, ACK, HOLD, REJECT} state_t;

    localparam logic [2:0] CNT_LAST = (ACK_DELAY > 0) ? 3'(ACK_DELAY - 1) : 3'd0;

    state_t     state;
    state_t     next_state;
    logic [3:0] lat_addr;
    logic [3:0] lat_data;
    logic [2:0] cnt;
    logic [3:0] regs [0:14];

    logic       commit;
    logic [3:0] commit_addr;
    logic [3:0] commit_data;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (locked && address != 4'hF)
                        next_state = REJECT;
                    else if (ACK_DELAY == 0)
                        next_state = ACK;
                    else
                        next_state = DELAY;
                end
            end
            DELAY:   if (cnt == CNT_LAST) next_state = ACK;
            ACK:     next_state = HOLD;
            HOLD:    if (!valid) next_state = IDLE;
            REJECT:  if (!valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With zero delay the commit edge is also the capture edge, so the live inputs are used.
    always_comb begin
        commit      = (next_state == ACK) && (state != ACK);
        commit_addr = (state == IDLE) ? address : lat_addr;
        commit_data = (state == IDLE) ? data    : lat_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_data   <= '0;
            cnt        <= '0;
            ack        <= 1'b0;
            rd_data    <= '0;
            locked     <= 1'b0;
            reject_cnt <= '0;
            for (int i = 0; i < 15; i++)
                regs[i] <= '0;
        end else begin
            state <= next_state;
            ack   <= (next_state == ACK);

            if (state == IDLE && valid) begin
                lat_addr <= address;
                lat_data <= data;
                cnt      <= '0;
            end else if (state == DELAY) begin
                cnt <= cnt + 3'd1;
            end

            if (commit) begin
                if (commit_addr == 4'hF) begin
                    if (commit_data == LOCK_KEY)
                        locked <= 1'b1;
                    else if (commit_data == UNLOCK_KEY)
                        locked <= 1'b0;
                end else begin
                    regs[commit_addr] <= commit_data;
                end
            end

            if (state != REJECT && next_state == REJECT && reject_cnt != 8'hFF)
                reject_cnt <= reject_cnt + 8'd1;

            // Reads see the pre-commit contents when they coincide with a write.
            rd_data <= (rd_addr == 4'hF) ? {3'b000, locked} : regs[rd_addr];
        end
    end

    always_comb begin
        cfg_bus = '0;
        for (int n = 0; n < 15; n++)
            cfg_bus[4*n +: 4] = regs[n];
    end

endmodule
